// File: rtl/glitch_ctrl_pkg.sv
// Shared types and constants for the glitch sequencer.
// Optional trigger synchronizer: GLITCH_TRIG_SYNC_EN.
`timescale 1ns/1ps
package glitch_ctrl_pkg;

  localparam int DLY_W_DEF = 32;
  localparam int WID_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_GLITCH,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic logic [31:0] eff_len(
    input logic [31:0] x
  );
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/glitch_trig_edge.sv
// Trigger rise detector; GLITCH_TRIG_SYNC_EN adds a
// 2-flop synchronizer in front of the edge flop.
`timescale 1ns/1ps
module glitch_trig_edge (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic trig_rise
);

  logic trig_s;
  logic trig_q;

`ifdef GLITCH_TRIG_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], trigger};
    end
  end

  assign trig_s = sync[1];
`else
  assign trig_s = trigger;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_q;

endmodule

// File: rtl/glitch_ctrl.sv
// Clock-glitch sequencer: arm, wait for trigger, delay, pulse train.
// Optional trigger synchronizer: GLITCH_TRIG_SYNC_EN.
`timescale 1ns/1ps
module glitch_ctrl
  import glitch_ctrl_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF,
  parameter int WID_W = WID_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [DLY_W-1:0] cfg_delay_i,
  input  logic [WID_W-1:0] cfg_width_i,
  input  logic [WID_W-1:0] cfg_gap_i,
  input  logic [CNT_W-1:0] cfg_count_i,
  input  logic             trigger_i,
  output logic             glitch_en_o,
  output logic             clk_sel_o,
  output logic             armed_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [DLY_W-1:0] ONE_D = DLY_W'(1);
  localparam logic [WID_W-1:0] ONE_W = WID_W'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t state;
  state_t next;

  logic [DLY_W-1:0] lat_delay;
  logic [WID_W-1:0] lat_width;
  logic [WID_W-1:0] lat_gap;
  logic [CNT_W-1:0] lat_count;

  logic [DLY_W-1:0] dcnt;
  logic [WID_W-1:0] wcnt;
  logic [WID_W-1:0] gcnt;
  logic [CNT_W-1:0] pcnt;

  logic trig_rise;
  logic run_next;

  glitch_trig_edge u_edge (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger_i),
    .trig_rise (trig_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    if (abort_i) begin
      next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (arm_i) next = ST_ARMED;
        end
        ST_ARMED: begin
          if (trig_rise) begin
            if (lat_count == '0)
              next = ST_DONE;
            else if (lat_delay == '0)
              next = ST_GLITCH;
            else
              next = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (dcnt == '0) next = ST_GLITCH;
        end
        ST_GLITCH: begin
          if (wcnt == lat_width - ONE_W)
            next = (pcnt > ONE_C) ? ST_GAP : ST_DONE;
        end
        ST_GAP: begin
          if (gcnt == lat_gap - ONE_W) next = ST_GLITCH;
        end
        ST_DONE: next = ST_IDLE;
        default: next = ST_IDLE;
      endcase
    end
  end

  // Config is captured only on a real arm from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_delay <= '0;
      lat_width <= '0;
      lat_gap   <= '0;
      lat_count <= '0;
    end else if (state == ST_IDLE && next == ST_ARMED) begin
      lat_delay <= cfg_delay_i;
      lat_width <= WID_W'(eff_len(32'(cfg_width_i)));
      lat_gap   <= WID_W'(eff_len(32'(cfg_gap_i)));
      lat_count <= cfg_count_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
      wcnt <= '0;
      gcnt <= '0;
      pcnt <= '0;
    end else begin
      if (state == ST_ARMED)
        dcnt <= lat_delay - ONE_D;
      else if (state == ST_DELAY && dcnt != '0)
        dcnt <= dcnt - ONE_D;

      if (state == ST_GLITCH && next == ST_GLITCH)
        wcnt <= wcnt + ONE_W;
      else
        wcnt <= '0;

      if (state == ST_GAP && next == ST_GAP)
        gcnt <= gcnt + ONE_W;
      else
        gcnt <= '0;

      if (state == ST_ARMED)
        pcnt <= lat_count;
      else if (state == ST_GLITCH && next == ST_GAP)
        pcnt <= pcnt - ONE_C;
    end
  end

  assign run_next = (next == ST_DELAY) ||
                    (next == ST_GLITCH) ||
                    (next == ST_GAP);

  // Outputs follow next state so they are glitch-free flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_en_o <= 1'b0;
      clk_sel_o   <= 1'b0;
      armed_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      glitch_en_o <= (next == ST_GLITCH);
      clk_sel_o   <= run_next;
      armed_o     <= (next == ST_ARMED);
      busy_o      <= run_next;
      done_o      <= (next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_glitch_ctrl.sv
// Scoreboard bench for glitch_ctrl; expected output vectors are
// queued per cycle by the stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_glitch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm_i;
  logic        abort_i;
  logic [31:0] cfg_delay_i;
  logic [7:0]  cfg_width_i;
  logic [7:0]  cfg_gap_i;
  logic [7:0]  cfg_count_i;
  logic        trigger_i;
  logic        glitch_en_o;
  logic        clk_sel_o;
  logic        armed_o;
  logic        busy_o;
  logic        done_o;

`ifdef GLITCH_TRIG_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  glitch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm_i),
    .abort_i     (abort_i),
    .cfg_delay_i (cfg_delay_i),
    .cfg_width_i (cfg_width_i),
    .cfg_gap_i   (cfg_gap_i),
    .cfg_count_i (cfg_count_i),
    .trigger_i   (trigger_i),
    .glitch_en_o (glitch_en_o),
    .clk_sel_o   (clk_sel_o),
    .armed_o     (armed_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // vector order: {glitch_en, clk_sel, armed, busy, done}
  typedef struct {
    int         c;
    logic [4:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input int c, input logic [4:0] v,
                      input string nm);
    exp_t e;
    e.c = c;
    e.v = v;
    e.nm = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [4:0] got;
    exp_t e;
    got = {glitch_en_o, clk_sel_o, armed_o, busy_o, done_o};
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.c < cyc) begin
        errors++;
        $display("FAIL %s missed cyc=%0d now=%0d", e.nm, e.c, cyc);
      end else if (got !== e.v) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%b exp=%b",
                 e.nm, cyc, got, e.v);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Timeline from trigger cycle t; after cut all outputs stay 0.
  task automatic sched(input int t, input int d, input int w,
                       input int g, input int n, input int cut,
                       input string nm, output int fin);
    int ew, eg, s0, dn;
    logic gl, sl, dl;
    ew = (w == 0) ? 1 : w;
    eg = (g == 0) ? 1 : g;
    s0 = t + 1 + d;
    dn = (n == 0) ? t + 1 : s0 + n * ew + (n - 1) * eg;
    fin = (cut >= 0) ? cut + 4 : dn + 1;
    for (int c = t + 1; c <= fin; c++) begin
      gl = 1'b0;
      sl = 1'b0;
      dl = 1'b0;
      if (cut < 0 || c <= cut) begin
        dl = (c == dn);
        if (n > 0) begin
          sl = (c > t && c < dn);
          for (int k = 0; k < n; k++)
            if (c >= s0 + k * (ew + eg) &&
                c <  s0 + k * (ew + eg) + ew)
              gl = 1'b1;
        end
      end
      push(c, {gl, sl, 1'b0, sl, dl}, nm);
    end
  endtask

  task automatic do_arm(input int d, input int w,
                        input int g, input int n);
    @(posedge clk);
    #1;
    cfg_delay_i = 32'(d);
    cfg_width_i = 8'(w);
    cfg_gap_i   = 8'(g);
    cfg_count_i = 8'(n);
    arm_i = 1'b1;
    push(cyc + 1, 5'b00100, "armed");
    @(posedge clk);
    #1;
    arm_i = 1'b0;
    cfg_delay_i = 32'd9;
    cfg_width_i = 8'd7;
    cfg_gap_i   = 8'd5;
    cfg_count_i = 8'd6;
  endtask

  task automatic run(input int d, input int w, input int g,
                     input int n, input string nm);
    int t, fin;
    do_arm(d, w, g, n);
    trigger_i = 1'b1;
    t = cyc + SYNC;
    sched(t, d, w, g, n, -1, nm, fin);
    wait_cyc(t + 1);
    trigger_i = 1'b0;
    wait_cyc(fin + 3);
  endtask

  int t, fin, a1, guard;

  initial begin
    rst = 1'b1;
    arm_i = 1'b0;
    abort_i = 1'b0;
    trigger_i = 1'b0;
    cfg_delay_i = '0;
    cfg_width_i = '0;
    cfg_gap_i = '0;
    cfg_count_i = '0;
    push(2, 5'b00000, "reset");
    push(3, 5'b00000, "reset");
    push(4, 5'b00000, "idle");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(6);

    run(3, 2, 0, 1, "basic");
    run(0, 1, 2, 3, "train");
    run(0, 1, 0, 0, "count0");
    run(0, 0, 0, 2, "w0g0");
    run(1, 3, 1, 2, "d1");

    // trigger already high when armed
    trigger_i = 1'b1;
    wait_cyc(cyc + 3);
    do_arm(2, 1, 0, 1);
    a1 = cyc;
    for (int c = a1 + 1; c <= a1 + 8; c++)
      push(c, 5'b00100, "prehigh");
    wait_cyc(a1 + 5);
    trigger_i = 1'b0;
    wait_cyc(a1 + 9);
    trigger_i = 1'b1;
    t = cyc + SYNC;
    sched(t, 2, 1, 0, 1, -1, "prehigh_run", fin);
    wait_cyc(t + 1);
    trigger_i = 1'b0;
    wait_cyc(fin + 3);

    // extra trigger edges and an arm during DELAY
    do_arm(6, 1, 0, 1);
    trigger_i = 1'b1;
    t = cyc + SYNC;
    sched(t, 6, 1, 0, 1, -1, "retrig", fin);
    wait_cyc(t + 2);
    trigger_i = 1'b0;
    wait_cyc(t + 3);
    trigger_i = 1'b1;
    arm_i = 1'b1;
    cfg_count_i = 8'd3;
    wait_cyc(t + 4);
    trigger_i = 1'b0;
    arm_i = 1'b0;
    wait_cyc(fin + 3);

    // abort in pulse 2 of 4
    do_arm(0, 2, 1, 4);
    trigger_i = 1'b1;
    t = cyc + SYNC;
    sched(t, 0, 2, 1, 4, t + 4, "abort", fin);
    wait_cyc(t + 1);
    trigger_i = 1'b0;
    wait_cyc(t + 4);
    abort_i = 1'b1;
    wait_cyc(t + 5);
    abort_i = 1'b0;
    wait_cyc(fin + 3);

    // reset in pulse 2 of 4
    do_arm(0, 2, 1, 4);
    trigger_i = 1'b1;
    t = cyc + SYNC;
    sched(t, 0, 2, 1, 4, t + 4, "rst_mid", fin);
    wait_cyc(t + 1);
    trigger_i = 1'b0;
    wait_cyc(t + 4);
    rst = 1'b1;
    wait_cyc(t + 5);
    rst = 1'b0;
    wait_cyc(fin + 3);

    run(3, 2, 0, 1, "basic_again");

    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
